totient_seq_ctrl: RTL and testbench

Sequencing controller for the Euler-totient display path. It owns the table index (0..15) that feeds the totient lookup ROM and seven-segment decoder, and decides when and in which direction it moves. Supports free-run stepping from a prescaled tick, pause with manual single-step, four traversal modes, and a programmable dwell at endpoints in bounce mode. It replaces the fixed per-clock index counter with a controlled, observable sequencer.

---
 rtl/totient_seq_ctrl_pkg.sv | 20 ++
 rtl/totient_seq_ctrl_if.sv | 22 ++
 rtl/totient_seq_ctrl_tick_gen.sv | 34 +++
 rtl/totient_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_totient_seq_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/totient_seq_ctrl_pkg.sv
// Shared types and constants for the totient display sequencer.
package totient_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_FWD    = 2'b01,
    MODE_REV    = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DWELL = 2'b10
  } state_e;

  localparam int IDX_RESET = 1;
  localparam int IDX_MAX   = 15;

endpackage

// File: rtl/totient_seq_ctrl_if.sv
// Control/status bundle between the sequencer and whoever drives it.
interface totient_seq_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             run_i;
  logic             step_i;
  logic [1:0]       mode_i;
  logic [IDX_W-1:0] index_o;
  logic             dir_o;
  logic             step_o;
  logic [1:0]       state_o;

  modport master (
    output run_i, step_i, mode_i,
    input  index_o, dir_o, step_o, state_o
  );

  modport slave (
    input  run_i, step_i, mode_i,
    output index_o, dir_o, step_o, state_o
  );
endinterface

// File: rtl/totient_seq_ctrl_tick_gen.sv
// Prescale counter: tick_o is high on the last cycle of each PRESCALE-cycle period while enabled.
module totient_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/totient_seq_ctrl.sv
// Index sequencer for the totient ROM/decoder: free-run, pause/single-step, four traversal modes, endpoint dwell.
module totient_seq_ctrl
  import totient_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int DWELL    = 2,
  parameter int IDX_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  totient_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DWELL = ST_DWELL;

  localparam logic [IDX_W-1:0] IDX_TOP  = '1;
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(IDX_RESET);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  mode_e            mode;
  logic             tick;
  logic             at_end;
  logic             adv_dir;
  logic [IDX_W-1:0] adv_idx;

  assign mode = mode_e'(bus.mode_i);

  // Counter is cleared while idle and on the edge that drops back to idle.
  totient_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .en_i   (state_q != S_IDLE),
    .clr_i  ((state_q == S_IDLE) || !bus.run_i),
    .tick_o (tick)
  );

  // Result of one advance from the current index/dir; bounce endpoints turn around and move at once.
  always_comb begin
    at_end  = (mode == MODE_BOUNCE) && (dir_q ? (idx_q == '0) : (idx_q == IDX_TOP));
    adv_dir = dir_q;
    adv_idx = idx_q;
    case (mode)
      MODE_BOUNCE: begin
        adv_dir = dir_q ^ at_end;
        adv_idx = adv_dir ? idx_q - 1'b1 : idx_q + 1'b1;
      end
      MODE_FWD: begin
        adv_dir = 1'b0;
        adv_idx = idx_q + 1'b1;
      end
      MODE_REV: begin
        adv_dir = 1'b1;
        adv_idx = idx_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    case (state_q)
      S_IDLE: begin
        if (bus.step_i) begin
          idx_d = adv_idx;
          dir_d = adv_dir;
        end
        if (bus.run_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.run_i) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (at_end && (DWELL > 0)) begin
            state_d = S_DWELL;
            dwell_d = '0;
          end else begin
            idx_d = adv_idx;
            dir_d = adv_dir;
          end
        end
      end
      S_DWELL: begin
        if (!bus.run_i) begin
          state_d = S_IDLE;
        end else if (tick) begin
          // Exit applies whatever mode is current now, from the held index.
          if (dwell_q == DW_LAST) begin
            state_d = S_RUN;
            idx_d   = adv_idx;
            dir_d   = adv_dir;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    step_d = (idx_d != idx_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_INIT;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.index_o = idx_q;
  assign bus.dir_o   = dir_q;
  assign bus.step_o  = step_q;
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_totient_seq_ctrl.sv
// Directed plus random checks of totient_seq_ctrl against an integer reference model.
module tb_totient_seq_ctrl;
  localparam int PRESCALE = 4;
  localparam int DWELL    = 2;
  localparam int IDX_W    = 4;
  localparam int IMAX     = (1 << IDX_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // reference model state: phase 0 idle, 1 run, 2 dwell
  int m_idx, m_ph, m_wait, m_dleft;
  bit m_dir, m_step;

  totient_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();

  totient_seq_ctrl #(.PRESCALE(PRESCALE), .DWELL(DWELL), .IDX_W(IDX_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int x);
    return x & IMAX;
  endfunction

  task automatic model_reset();
    m_idx = 1; m_dir = 0; m_ph = 0; m_wait = PRESCALE; m_dleft = 0; m_step = 0;
  endtask

  function automatic bit model_at_end();
    return (!m_dir && m_idx == IMAX) || (m_dir && m_idx == 0);
  endfunction

  task automatic model_rule();
    case (bus.mode_i)
      2'd0: begin
        if (model_at_end()) m_dir = !m_dir;
        m_idx = wrap(m_idx + (m_dir ? -1 : 1));
      end
      2'd1: begin m_dir = 0; m_idx = wrap(m_idx + 1); end
      2'd2: begin m_dir = 1; m_idx = wrap(m_idx - 1); end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (m_ph == 0) begin
      if (bus.step_i) model_rule();
      if (bus.run_i) begin m_ph = 1; m_wait = PRESCALE; end
    end else if (!bus.run_i) begin
      m_ph = 0;
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_wait = PRESCALE;
        if (m_ph == 1) begin
          if (bus.mode_i == 2'd0 && model_at_end() && DWELL > 0) begin
            m_ph = 2; m_dleft = DWELL;
          end else begin
            model_rule();
          end
        end else begin
          m_dleft--;
          if (m_dleft == 0) begin model_rule(); m_ph = 1; end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".index"}, 32'(bus.index_o), 32'(m_idx));
    chk({tag, ".dir"},   32'(bus.dir_o),   32'(m_dir));
    chk({tag, ".step"},  32'(bus.step_o),  32'(m_step));
    chk({tag, ".state"}, 32'(bus.state_o), 32'(m_ph));
  endtask

  task automatic cyc();
    int prev;
    @(posedge clock);
    prev = m_idx;
    if (reset) model_reset();
    else begin
      model_edge();
      m_step = (m_idx != prev);
    end
    #1;
    check_outputs("cycle");
  endtask

  initial begin
    int n;
    int cnt;
    logic [IDX_W-1:0] held;

    bus.run_i = 0; bus.step_i = 0; bus.mode_i = 2'd0;
    #1 reset = 1;
    #1;
    model_reset();
    chk("rst.index", 32'(bus.index_o), 32'd1);
    chk("rst.dir",   32'(bus.dir_o),   32'd0);
    chk("rst.step",  32'(bus.step_o),  32'd0);
    chk("rst.state", 32'(bus.state_o), 32'd0);
    cyc(); cyc();

    // 1: free-run from release, first advance PRESCALE+1 cycles later
    reset = 0; bus.run_i = 1;
    n = 0;
    do begin cyc(); n++; end while (!bus.step_o && n < 20);
    chk("first_adv_latency", 32'(n), 32'(PRESCALE + 1));
    chk("first_adv_index", 32'(bus.index_o), 32'd2);

    // 2: bounce dwell at 15 and at 0
    n = 0;
    while (bus.index_o !== 4'd15 && n < 200) begin cyc(); n++; end
    chk("reach15_timeout", 32'(n < 200), 32'd1);
    n = 0;
    while (bus.index_o !== 4'd14 && n < 60) begin cyc(); n++; end
    chk("dwell15_hold", 32'(n), 32'(3 * PRESCALE));
    chk("dwell15_dir", 32'(bus.dir_o), 32'd1);
    n = 0;
    while (bus.index_o !== 4'd0 && n < 200) begin cyc(); n++; end
    chk("reach0_timeout", 32'(n < 200), 32'd1);
    n = 0;
    while (bus.index_o !== 4'd1 && n < 60) begin cyc(); n++; end
    chk("dwell0_hold", 32'(n), 32'(3 * PRESCALE));
    chk("dwell0_dir", 32'(bus.dir_o), 32'd0);

    // 3: pause at 15 and single-step through the endpoint
    n = 0;
    while (bus.index_o !== 4'd15 && n < 200) begin cyc(); n++; end
    bus.run_i = 0;
    cyc();
    chk("pause15_state", 32'(bus.state_o), 32'd0);
    chk("pause15_index", 32'(bus.index_o), 32'd15);
    bus.step_i = 1;
    cyc();
    bus.step_i = 0;
    chk("step15_index", 32'(bus.index_o), 32'd14);
    chk("step15_dir",   32'(bus.dir_o),   32'd1);
    chk("step15_pulse", 32'(bus.step_o),  32'd1);
    bus.run_i = 1;
    cyc(); cyc();
    bus.step_i = 1;
    cyc();
    bus.step_i = 0;
    repeat (3) cyc();
    bus.run_i = 0;
    cyc();

    // 4: wrap modes by manual steps, then hold
    bus.mode_i = 2'd1; bus.step_i = 1;
    n = 0;
    while (bus.index_o !== 4'd15 && n < 40) begin cyc(); n++; end
    cyc();
    chk("fwd_wrap_index", 32'(bus.index_o), 32'd0);
    chk("fwd_wrap_dir",   32'(bus.dir_o),   32'd0);
    bus.mode_i = 2'd2;
    cyc();
    bus.step_i = 0;
    chk("rev_wrap_index", 32'(bus.index_o), 32'd15);
    chk("rev_wrap_dir",   32'(bus.dir_o),   32'd1);
    bus.mode_i = 2'd3; bus.run_i = 1;
    held = bus.index_o;
    cnt = 0;
    repeat (20) begin cyc(); if (bus.step_o) cnt++; end
    chk("hold_steps", 32'(cnt), 32'd0);
    chk("hold_index", 32'(bus.index_o), 32'(held));

    // 5: drop run on a tick edge, then restart latency
    bus.mode_i = 2'd1;
    n = 0;
    while (!(m_ph == 1 && m_wait == 1) && n < 20) begin cyc(); n++; end
    chk("tick_align_timeout", 32'(n < 20), 32'd1);
    held = bus.index_o;
    bus.run_i = 0;
    cyc();
    chk("drop_tick_index", 32'(bus.index_o), 32'(held));
    chk("drop_tick_state", 32'(bus.state_o), 32'd0);
    bus.run_i = 1;
    n = 0;
    do begin cyc(); n++; end while (!bus.step_o && n < 20);
    chk("restart_latency", 32'(n), 32'(PRESCALE + 1));

    // 6: reset while dwelling at 15
    bus.mode_i = 2'd0;
    n = 0;
    while (!(bus.state_o === 2'b10 && bus.index_o === 4'd15) && n < 600) begin cyc(); n++; end
    chk("dwell15_reach_timeout", 32'(n < 600), 32'd1);
    reset = 1;
    #1;
    chk("midrst.index", 32'(bus.index_o), 32'd1);
    chk("midrst.dir",   32'(bus.dir_o),   32'd0);
    chk("midrst.state", 32'(bus.state_o), 32'd0);
    chk("midrst.step",  32'(bus.step_o),  32'd0);
    model_reset();
    bus.run_i = 0;
    cyc(); cyc();
    reset = 0;
    cnt = 0;
    repeat (5) begin cyc(); if (bus.step_o) cnt++; end
    chk("post_release_steps", 32'(cnt), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) bus.run_i = ~bus.run_i;
      bus.step_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) bus.mode_i = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
